dmem_port_arbiter: RTL

//  Shares the single-port data memory between the pipeline MEM stage and the

---
 rtl/dmem_port_arbiter_pkg.sv | 27 ++
 rtl/dmem_port_arbiter_if.sv | 40 ++++
 rtl/dmem_port_arbiter_dmem_array.sv | 30 +++
 rtl/dmem_port_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and default parameters for the data-memory port arbiter.
// Contents:
//   block        - one memory word (DATA_W bits)
//   addr_t       - word address (ADDR_W bits); addresses wrap modulo DEPTH
//   rsp_owner_e  - which requester owns the read response in flight
package dmem_port_arbiter_pkg;

  localparam int unsigned DATA_W           = 16;
  localparam int unsigned ADDR_W           = 6;
  localparam int unsigned DEPTH            = 32'd1 << ADDR_W;
  localparam int unsigned MAX_WAIT_DEFAULT = 4;

  typedef logic [DATA_W-1:0] block;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PIPE = 2'd1,
    OWN_LD   = 2'd2
  } rsp_owner_e;

  // Response data is forced to zero whenever its valid flag is low.
  function automatic block gate_data(input logic valid, input block data);
    return valid ? data : block'(0);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the pipeline MEM-stage and loader/debug request/response signals.
// Modports:
//   master - requester side (drives pipe_* and ld_* requests, sees responses)
//   slave  - arbiter side (sees requests, drives stall/ready and responses)
interface dmem_port_arbiter_if import dmem_port_arbiter_pkg::*; ;

  // Pipeline MEM stage
  logic  pipe_req;
  logic  pipe_we;
  addr_t pipe_addr;
  block  pipe_wdata;
  logic  pipe_flush;
  logic  pipe_stall;
  logic  pipe_rvalid;
  block  pipe_rdata;

  // Loader / debug port
  logic  ld_valid;
  logic  ld_ready;
  logic  ld_we;
  addr_t ld_addr;
  block  ld_wdata;
  logic  ld_rvalid;
  block  ld_rdata;

  modport master (
    output pipe_req, pipe_we, pipe_addr, pipe_wdata, pipe_flush,
    input  pipe_stall, pipe_rvalid, pipe_rdata,
    output ld_valid, ld_we, ld_addr, ld_wdata,
    input  ld_ready, ld_rvalid, ld_rdata
  );

  modport slave (
    input  pipe_req, pipe_we, pipe_addr, pipe_wdata, pipe_flush,
    output pipe_stall, pipe_rvalid, pipe_rdata,
    input  ld_valid, ld_we, ld_addr, ld_wdata,
    output ld_ready, ld_rvalid, ld_rdata
  );

endinterface

// File: rtl/dmem_port_arbiter_dmem_array.sv
// Single-port synchronous data memory, DEPTH x DATA_W.
// Ports:
//   clk     - clock
//   we_i    - write enable; wdata_i stored at addr_i on the clock edge
//   addr_i  - word address
//   wdata_i - write data
//   rdata_o - registered read data of addr_i (one cycle latency)
// Contents are intentionally not reset; the loader initialises them.
module dmem_array import dmem_port_arbiter_pkg::*; (
  input  logic  clk,
  input  logic  we_i,
  input  addr_t addr_i,
  input  block  wdata_i,
  output block  rdata_o
);

  block mem_q [DEPTH];
  block rdata_q;

  // Storage write and registered read port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage
// (priority) and the loader/debug port. A starvation counter forces a loader
// slot after MAX_WAIT consecutive pipe grants while the loader waits.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - request/response bundle (slave modport)
// pipe_stall and ld_ready are combinational; read responses come one cycle
// after the grant and are routed by the registered response owner.
module dmem_port_arbiter import dmem_port_arbiter_pkg::*; #(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  rsp_owner_e       rsp_owner_q, rsp_owner_d;

  logic  pipe_live_s;
  logic  ld_grant_s;
  logic  pipe_grant_s;
  logic  mem_we_s;
  addr_t mem_addr_s;
  block  mem_wdata_s;
  block  mem_rdata_s;
  logic  pipe_rvalid_s;
  logic  ld_rvalid_s;

  // Grant decision, memory request mux and next-state for counter/owner.
  always_comb begin
    pipe_live_s  = bus.pipe_req & ~bus.pipe_flush;
    // No grants while in reset so the array is left untouched.
    ld_grant_s   = ~rst & bus.ld_valid &
                   (~pipe_live_s | (starve_cnt_q == CNT_W'(MAX_WAIT)));
    pipe_grant_s = ~rst & pipe_live_s & ~ld_grant_s;

    mem_we_s    = 1'b0;
    mem_addr_s  = bus.pipe_addr;
    mem_wdata_s = bus.pipe_wdata;
    if (ld_grant_s) begin
      mem_we_s    = bus.ld_we;
      mem_addr_s  = bus.ld_addr;
      mem_wdata_s = bus.ld_wdata;
    end else if (pipe_grant_s) begin
      mem_we_s    = bus.pipe_we;
    end else begin
      mem_we_s    = 1'b0;
    end

    starve_cnt_d = starve_cnt_q;
    if (~bus.ld_valid | ld_grant_s) begin
      starve_cnt_d = '0;
    end else if (pipe_grant_s && (starve_cnt_q < CNT_W'(MAX_WAIT))) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    rsp_owner_d = OWN_NONE;
    if (ld_grant_s && !bus.ld_we) begin
      rsp_owner_d = OWN_LD;
    end else if (pipe_grant_s && !bus.pipe_we) begin
      rsp_owner_d = OWN_PIPE;
    end else begin
      rsp_owner_d = OWN_NONE;
    end
  end

  // Starvation counter and response-owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rsp_owner_q  <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

  dmem_array u_dmem_array (
    .clk     (clk),
    .we_i    (mem_we_s),
    .addr_i  (mem_addr_s),
    .wdata_i (mem_wdata_s),
    .rdata_o (mem_rdata_s)
  );

  // Response routing; a flush in the response cycle discards a pipe read.
  always_comb begin
    pipe_rvalid_s = 1'b0;
    ld_rvalid_s   = 1'b0;
    case (rsp_owner_q)
      OWN_PIPE: pipe_rvalid_s = ~rst & ~bus.pipe_flush;
      OWN_LD:   ld_rvalid_s   = ~rst;
      OWN_NONE: begin
        pipe_rvalid_s = 1'b0;
        ld_rvalid_s   = 1'b0;
      end
      default: begin
        pipe_rvalid_s = 1'b0;
        ld_rvalid_s   = 1'b0;
      end
    endcase
  end

  assign bus.ld_ready    = ld_grant_s;
  assign bus.pipe_stall  = ~rst & pipe_live_s & ~pipe_grant_s;
  assign bus.pipe_rvalid = pipe_rvalid_s;
  assign bus.pipe_rdata  = gate_data(pipe_rvalid_s, mem_rdata_s);
  assign bus.ld_rvalid   = ld_rvalid_s;
  assign bus.ld_rdata    = gate_data(ld_rvalid_s, mem_rdata_s);

endmodule
